// File: rtl/ppg_ratio_calc_if.sv
// Sample stream in, per-window SpO2 ratio and AC/DC results out.
interface ppg_ratio_calc_if;
  logic        enable;
  logic        sample_valid;
  logic        sample_is_red;
  logic [7:0]  sample;
  logic        busy;
  logic        ratio_valid;
  logic [15:0] ratio;
  logic        err_div0;
  logic [7:0]  ac_red;
  logic [7:0]  dc_red;
  logic [7:0]  ac_ir;
  logic [7:0]  dc_ir;

  modport master (
    output enable, sample_valid, sample_is_red, sample,
    input  busy, ratio_valid, ratio, err_div0, ac_red, dc_red, ac_ir, dc_ir
  );

  modport slave (
    input  enable, sample_valid, sample_is_red, sample,
    output busy, ratio_valid, ratio, err_div0, ac_red, dc_red, ac_ir, dc_ir
  );
endinterface

// File: rtl/ppg_ratio_calc.sv
// Per-window RED/IR max/min/sum tracking and SpO2 ratio
// R = (AC_red*DC_ir)/(AC_ir*DC_red) via a bit-serial restoring divider.
//
// state  | meaning
// IDLE   | disabled, trackers held cleared
// ACCUM  | accumulating samples of both channels
// MUL    | latch AC/DC, form numerator and denominator
// DIV    | one quotient bit per cycle, MSB first
// DONE   | results presented, ratio_valid pulse
module ppg_ratio_calc #(
  parameter int WIN_LOG2  = 8,
  parameter int FRAC_BITS = 8
) (
  input logic            CLK,
  input logic            rst,
  ppg_ratio_calc_if.slave io
);
  localparam int SW = 8 + WIN_LOG2;
  localparam int CW = WIN_LOG2 + 1;
  localparam int QW = 16 + FRAC_BITS;
  localparam int DW = $clog2(QW);
  localparam logic [CW-1:0] FULL = CW'(2 ** WIN_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      max_red_q, max_red_d, min_red_q, min_red_d;
  logic [7:0]      max_ir_q, max_ir_d, min_ir_q, min_ir_d;
  logic [SW-1:0]   sum_red_q, sum_red_d, sum_ir_q, sum_ir_d;
  logic [CW-1:0]   cnt_red_q, cnt_red_d, cnt_ir_q, cnt_ir_d;
  logic [7:0]      lacr_q, lacr_d, ldcr_q, ldcr_d, laci_q, laci_d, ldci_q, ldci_d;
  logic [15:0]     den_q, den_d, rem_q, rem_d;
  logic [QW-1:0]   dvd_q, dvd_d, quo_q, quo_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [15:0]     ratio_q, ratio_d;
  logic            err_q, err_d;
  logic [7:0]      acr_q, acr_d, dcr_q, dcr_d, aci_q, aci_d, dci_q, dci_d;

  logic [7:0]      acr_w, dcr_w, aci_w, dci_w;
  logic [15:0]     num_w, den_w;
  logic [16:0]     rem_sh;
  logic            q_bit, clr, load;
  logic [15:0]     n_ratio;
  logic            n_err;
  logic [7:0]      n_acr, n_dcr, n_aci, n_dci;

  // Next-state, tracker update, divider step and result capture
  always_comb begin
    state_d   = state_q;
    max_red_d = max_red_q;  min_red_d = min_red_q;
    sum_red_d = sum_red_q;  cnt_red_d = cnt_red_q;
    max_ir_d  = max_ir_q;   min_ir_d  = min_ir_q;
    sum_ir_d  = sum_ir_q;   cnt_ir_d  = cnt_ir_q;
    lacr_d = lacr_q; ldcr_d = ldcr_q; laci_d = laci_q; ldci_d = ldci_q;
    den_d = den_q; rem_d = rem_q; dvd_d = dvd_q; quo_d = quo_q; div_cnt_d = div_cnt_q;
    ratio_d = ratio_q; err_d = err_q;
    acr_d = acr_q; dcr_d = dcr_q; aci_d = aci_q; dci_d = dci_q;
    clr = 1'b0; load = 1'b0;
    n_ratio = 16'h0; n_err = 1'b0;
    n_acr = lacr_q; n_dcr = ldcr_q; n_aci = laci_q; n_dci = ldci_q;

    acr_w  = max_red_q - min_red_q;
    aci_w  = max_ir_q - min_ir_q;
    dcr_w  = sum_red_q[SW-1:WIN_LOG2];
    dci_w  = sum_ir_q[SW-1:WIN_LOG2];
    num_w  = {8'h0, acr_w} * {8'h0, dci_w};
    den_w  = {8'h0, aci_w} * {8'h0, dcr_w};
    rem_sh = {rem_q, dvd_q[QW-1]};
    q_bit  = (rem_sh >= {1'b0, den_q});

    case (state_q)
      S_IDLE: begin
        clr = 1'b1;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (io.sample_valid) begin
          if (io.sample_is_red && cnt_red_q < FULL) begin
            if (io.sample > max_red_q) max_red_d = io.sample;
            if (io.sample < min_red_q) min_red_d = io.sample;
            sum_red_d = sum_red_q + SW'(io.sample);
            cnt_red_d = cnt_red_q + CW'(1);
          end else if (!io.sample_is_red && cnt_ir_q < FULL) begin
            if (io.sample > max_ir_q) max_ir_d = io.sample;
            if (io.sample < min_ir_q) min_ir_d = io.sample;
            sum_ir_d = sum_ir_q + SW'(io.sample);
            cnt_ir_d = cnt_ir_q + CW'(1);
          end
        end
        if (cnt_red_d == FULL && cnt_ir_d == FULL) state_d = S_MUL;
      end
      S_MUL: begin
        lacr_d = acr_w; ldcr_d = dcr_w; laci_d = aci_w; ldci_d = dci_w;
        den_d = den_w;
        rem_d = 16'h0;
        dvd_d = {num_w, {FRAC_BITS{1'b0}}};
        quo_d = '0;
        div_cnt_d = DW'(QW - 1);
        if (den_w == 16'h0) begin
          state_d = S_DONE;
          load = 1'b1;
          n_ratio = 16'hFFFF; n_err = 1'b1;
          n_acr = acr_w; n_dcr = dcr_w; n_aci = aci_w; n_dci = dci_w;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = q_bit ? 16'(rem_sh - {1'b0, den_q}) : rem_sh[15:0];
        quo_d = {quo_q[QW-2:0], q_bit};
        dvd_d = dvd_q << 1;
        div_cnt_d = div_cnt_q - DW'(1);
        if (div_cnt_q == '0) begin
          state_d = S_DONE;
          load = 1'b1;
          n_ratio = (|quo_d[QW-1:16]) ? 16'hFFFF : quo_d[15:0];
        end
      end
      S_DONE: begin
        clr = 1'b1;
        state_d = S_ACCUM;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping enable abandons the window and suppresses any pending result
    if (!io.enable) begin
      state_d = S_IDLE;
      load = 1'b0;
    end

    if (load) begin
      ratio_d = n_ratio; err_d = n_err;
      acr_d = n_acr; dcr_d = n_dcr; aci_d = n_aci; dci_d = n_dci;
    end

    if (clr) begin
      max_red_d = 8'h00; min_red_d = 8'hFF; sum_red_d = '0; cnt_red_d = '0;
      max_ir_d  = 8'h00; min_ir_d  = 8'hFF; sum_ir_d  = '0; cnt_ir_d  = '0;
    end
  end

  // State, tracker, divider and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      max_red_q <= 8'h00; min_red_q <= 8'hFF; sum_red_q <= '0; cnt_red_q <= '0;
      max_ir_q  <= 8'h00; min_ir_q  <= 8'hFF; sum_ir_q  <= '0; cnt_ir_q  <= '0;
      lacr_q <= '0; ldcr_q <= '0; laci_q <= '0; ldci_q <= '0;
      den_q <= '0; rem_q <= '0; dvd_q <= '0; quo_q <= '0; div_cnt_q <= '0;
      ratio_q <= '0; err_q <= 1'b0;
      acr_q <= '0; dcr_q <= '0; aci_q <= '0; dci_q <= '0;
    end else begin
      state_q <= state_d;
      max_red_q <= max_red_d; min_red_q <= min_red_d; sum_red_q <= sum_red_d; cnt_red_q <= cnt_red_d;
      max_ir_q  <= max_ir_d;  min_ir_q  <= min_ir_d;  sum_ir_q  <= sum_ir_d;  cnt_ir_q  <= cnt_ir_d;
      lacr_q <= lacr_d; ldcr_q <= ldcr_d; laci_q <= laci_d; ldci_q <= ldci_d;
      den_q <= den_d; rem_q <= rem_d; dvd_q <= dvd_d; quo_q <= quo_d; div_cnt_q <= div_cnt_d;
      ratio_q <= ratio_d; err_q <= err_d;
      acr_q <= acr_d; dcr_q <= dcr_d; aci_q <= aci_d; dci_q <= dci_d;
    end
  end

  assign io.busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_DONE);
  assign io.ratio_valid = (state_q == S_DONE);
  assign io.ratio       = ratio_q;
  assign io.err_div0    = err_q;
  assign io.ac_red      = acr_q;
  assign io.dc_red      = dcr_q;
  assign io.ac_ir       = aci_q;
  assign io.dc_ir       = dci_q;
endmodule

// File: tb/tb_ppg_ratio_calc.sv
// Scoreboard bench for ppg_ratio_calc: directed windows push expected results,
// a negedge monitor pops and compares on every ratio_valid.
module tb_ppg_ratio_calc;
  logic CLK = 1'b0;
  logic rst;
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  typedef struct {
    logic [15:0] ratio;
    logic        err;
    logic [7:0]  acr, dcr, aci, dci;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  ppg_ratio_calc_if io();

  ppg_ratio_calc #(.WIN_LOG2(8), .FRAC_BITS(8)) dut (
    .CLK (CLK),
    .rst (rst),
    .io  (io)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every ratio_valid must match the oldest expectation, on time
  always @(negedge CLK) begin
    if (!rst && io.ratio_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 32'(io.ratio), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("valid_cycle", 32'(cyc),         32'(e.cyc));
        chk("ratio",       32'(io.ratio),    32'(e.ratio));
        chk("err_div0",    32'(io.err_div0), 32'(e.err));
        chk("ac_red",      32'(io.ac_red),   32'(e.acr));
        chk("dc_red",      32'(io.dc_red),   32'(e.dcr));
        chk("ac_ir",       32'(io.ac_ir),    32'(e.aci));
        chk("dc_ir",       32'(io.dc_ir),    32'(e.dci));
      end
    end
  end

  task automatic send(input logic red, input logic [7:0] v);
    @(posedge CLK); #1;
    io.sample_valid  = 1'b1;
    io.sample_is_red = red;
    io.sample        = v;
    last_cyc         = cyc;
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      io.sample_valid = 1'b0;
    end
  endtask

  task automatic window(input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] i0, input logic [7:0] i1);
    for (int i = 0; i < 256; i++) begin
      send(1'b1, i[0] ? r1 : r0);
      send(1'b0, i[0] ? i1 : i0);
    end
  endtask

  task automatic expect_res(input logic [15:0] ratio, input logic err,
                            input logic [7:0] acr, input logic [7:0] dcr,
                            input logic [7:0] aci, input logic [7:0] dci, input int lat);
    exp_t e;
    e.ratio = ratio; e.err = err;
    e.acr = acr; e.dcr = dcr; e.aci = aci; e.dci = dci;
    e.cyc = last_cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(posedge CLK);
    chk("result_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
    quiet(2);
  endtask

  task automatic chk_zero_outputs(input string tag);
    @(negedge CLK);
    chk({tag, "_busy"},  32'(io.busy),        32'd0);
    chk({tag, "_valid"}, 32'(io.ratio_valid), 32'd0);
    chk({tag, "_ratio"}, 32'(io.ratio),       32'd0);
    chk({tag, "_err"},   32'(io.err_div0),    32'd0);
    chk({tag, "_acdc"},  32'({io.ac_red, io.dc_red, io.ac_ir, io.dc_ir}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    io.enable = 1'b0; io.sample_valid = 1'b0; io.sample_is_red = 1'b0; io.sample = 8'h0;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    chk_zero_outputs("reset");

    io.enable = 1'b1;
    quiet(2);

    // 1: nominal window, ratio exactly 2.0
    window(8'd100, 8'd140, 8'd110, 8'd130);
    expect_res(16'h0200, 1'b0, 8'd40, 8'd120, 8'd20, 8'd120, 26);
    quiet(1);
    wait_done();

    // 2: flat IR gives zero denominator
    window(8'd100, 8'd140, 8'd128, 8'd128);
    expect_res(16'hFFFF, 1'b1, 8'd40, 8'd120, 8'd0, 8'd128, 2);
    quiet(1);
    wait_done();
    @(negedge CLK);
    chk("err_div0_held", 32'(io.err_div0), 32'd1);

    // 3: quotient 130048 saturates without error
    window(8'd0, 8'd254, 8'd254, 8'd255);
    expect_res(16'hFFFF, 1'b0, 8'd254, 8'd127, 8'd1, 8'd254, 26);
    quiet(1);
    wait_done();

    // 4: surplus RED samples ignored, then samples dropped while busy
    for (int i = 0; i < 300; i++)
      send(1'b1, (i < 256) ? (i[0] ? 8'd140 : 8'd100) : (i[0] ? 8'd255 : 8'd0));
    for (int i = 0; i < 256; i++) send(1'b0, i[0] ? 8'd130 : 8'd110);
    expect_res(16'h0200, 1'b0, 8'd40, 8'd120, 8'd20, 8'd120, 26);
    for (int i = 0; i < 20; i++) begin
      send(i[1], i[0] ? 8'd255 : 8'd0);
      if (i == 10) begin
        @(negedge CLK);
        chk("busy_in_div", 32'(io.busy), 32'd1);
      end
    end
    quiet(1);
    wait_done();
    window(8'd60, 8'd100, 8'd90, 8'd110);
    expect_res(16'h0280, 1'b0, 8'd40, 8'd80, 8'd20, 8'd100, 26);
    quiet(1);
    wait_done();

    // 5: reset during DIV kills the result and clears outputs
    window(8'd100, 8'd140, 8'd110, 8'd130);
    quiet(10);
    rst = 1'b1;
    @(posedge CLK); #1 rst = 1'b0;
    chk_zero_outputs("rst_div");
    quiet(40);
    window(8'd60, 8'd100, 8'd90, 8'd110);
    expect_res(16'h0280, 1'b0, 8'd40, 8'd80, 8'd20, 8'd100, 26);
    quiet(1);
    wait_done();

    // 6: enable drop mid-window discards the partial window
    for (int i = 0; i < 128; i++) begin
      send(1'b1, i[0] ? 8'd254 : 8'd0);
      send(1'b0, i[0] ? 8'd255 : 8'd254);
    end
    quiet(1);
    io.enable = 1'b0;
    quiet(3);
    @(negedge CLK);
    chk("disabled_busy", 32'(io.busy), 32'd0);
    io.enable = 1'b1;
    quiet(2);
    window(8'd100, 8'd140, 8'd110, 8'd130);
    expect_res(16'h0200, 1'b0, 8'd40, 8'd120, 8'd20, 8'd120, 26);
    quiet(1);
    wait_done();

    quiet(30);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
